// File: rtl/requant_pkg.sv
// Shared widths, stage payload types and the output clamp for the requantisation pipeline.
package requant_pkg;

  localparam int PRECISION = 8;
  localparam int ACC_W     = 32;
  localparam int MUL_W     = 32;
  localparam int SHIFT_W   = 6;
  // Each width holds the worst-case magnitude of its stage exactly, so nothing wraps.
  localparam int SUB_W     = ACC_W + PRECISION + 1;
  localparam int PROD_W    = SUB_W + MUL_W + 1;
  localparam int SUM_W     = PROD_W + 1;

  typedef struct packed {
    logic signed [SUB_W-1:0] sub;
    logic signed [ACC_W-1:0] bias;
  } s1_pay_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  bias;
  } s2_pay_t;

  typedef struct packed {
    logic                 sat;
    logic [PRECISION-1:0] q;
  } clamp_t;

  function automatic clamp_t sat_clamp(input logic signed [SUM_W-1:0] v,
                                       input logic signed [SUM_W-1:0] lo,
                                       input logic signed [SUM_W-1:0] hi);
    clamp_t r;
    r.sat = 1'b1;
    r.q   = v[PRECISION-1:0];
    if (v > hi) begin
      r.q = hi[PRECISION-1:0];
    end else if (v < lo) begin
      r.q = lo[PRECISION-1:0];
    end else begin
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/requant_pipeline_lane.sv
// One lane of the S1..S4 requantisation datapath; the out register is the only reset data.
// Build option REQUANT_RELU_EN moves the lower clamp bound up to Z_OUT (fused ReLU).
module requant_lane
  import requant_pkg::*;
#(
  parameter int Z_WEIGHTS  = 5,
  parameter int Z_OUT      = 0,
  parameter int OUT_SIGNED = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic                       ld_i,
  input  logic signed [ACC_W-1:0]    acc_i,
  input  logic signed [ACC_W-1:0]    ai_i,
  input  logic signed [ACC_W-1:0]    bias_i,
  input  logic        [MUL_W-1:0]    mul_i,
  input  logic        [SHIFT_W-1:0]  shift_i,
  output logic        [PRECISION-1:0] q_o,
  output logic                       sat_o
);

  localparam logic signed [SUM_W-1:0] HI = (OUT_SIGNED != 0) ?
    SUM_W'((1 <<< (PRECISION - 1)) - 1) : SUM_W'((1 <<< PRECISION) - 1);
`ifdef REQUANT_RELU_EN
  localparam logic signed [SUM_W-1:0] LO = SUM_W'(Z_OUT);
`else
  localparam logic signed [SUM_W-1:0] LO = (OUT_SIGNED != 0) ?
    SUM_W'(-(1 <<< (PRECISION - 1))) : SUM_W'(0);
`endif

  function automatic logic signed [SUM_W-1:0] round_shift(input logic signed [PROD_W-1:0] p,
                                                          input logic [SHIFT_W-1:0]      s);
    logic signed [SUM_W-1:0] px;
    logic signed [SUM_W-1:0] half;
    px   = SUM_W'(p);
    half = (s == '0) ? SUM_W'(0) : (SUM_W'(1) <<< (s - SHIFT_W'(1)));
    return (px + half) >>> s;
  endfunction

  s1_pay_t                 s1_d, s1_q;
  s2_pay_t                 s2_d, s2_q;
  logic signed [SUM_W-1:0] sum_d, sum_q;
  clamp_t                  c4;
  logic [PRECISION-1:0]    q_q;

  // S1: remove the weight zero-point contribution
  assign s1_d.sub  = SUB_W'(acc_i) - SUB_W'(Z_WEIGHTS) * SUB_W'(ai_i);
  assign s1_d.bias = bias_i;

  // S2: signed x unsigned scale; M and SHIFT are read live since config only changes when empty
  assign s2_d.prod = PROD_W'($signed(s1_q.sub)) * PROD_W'($signed({1'b0, mul_i}));
  assign s2_d.bias = s1_q.bias;

  // S3: round half-up shift, then bias
  assign sum_d = round_shift($signed(s2_q.prod), shift_i) + SUM_W'($signed(s2_q.bias));

  // S4: output zero point and clamp
  assign c4 = sat_clamp(sum_q + SUM_W'(Z_OUT), LO, HI);

  always_ff @(posedge clk) begin
    if (en_i) begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (ld_i) begin
      q_q <= c4.q;
    end
  end

  assign q_o   = q_q;
  assign sat_o = c4.sat;

endmodule

// File: rtl/requant_pipeline.sv
// Multi-lane requantisation top: valid/stall control, per-lane M/SHIFT registers, sat_cnt.
// Optional build macro REQUANT_RELU_EN (fused ReLU lower bound) is handled inside requant_lane.
module requant_pipeline
  import requant_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int Z_WEIGHTS  = 5,
  parameter int Z_OUT      = 0,
  parameter int OUT_SIGNED = 1,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CH*ACC_W-1:0]     acc,
  input  logic [ACC_W-1:0]          ai,
  input  logic [N_CH*ACC_W-1:0]     bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_CH*PRECISION-1:0] out_q,
  input  logic                      cfg_we,
  output logic                      cfg_ready,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [MUL_W-1:0]          cfg_mul,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  output logic [15:0]               sat_cnt
);

  logic               vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
  logic               en, ld, cfg_hold, accept;
  logic [MUL_W-1:0]   mul_q   [N_CH];
  logic [SHIFT_W-1:0] shift_q [N_CH];
  logic [N_CH-1:0]    lane_sat;
  logic [16:0]        sat_sum;
  logic [15:0]        sat_cnt_d, sat_cnt_q;

  assign en        = !vld_p4_q || out_ready;
  assign ld        = en && vld_p3_q;
  assign cfg_ready = !(vld_p1_q || vld_p2_q || vld_p3_q || vld_p4_q);
  assign cfg_hold  = cfg_we && cfg_ready;
  assign in_ready  = en && !cfg_hold;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p4_q;
  assign sat_cnt   = sat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        mul_q[i]   <= MUL_W'(1);
        shift_q[i] <= '0;
      end
    end else if (cfg_hold && (32'(cfg_ch) < 32'(N_CH))) begin
      mul_q[cfg_ch]   <= cfg_mul;
      shift_q[cfg_ch] <= cfg_shift;
    end
  end

  always_comb begin
    sat_sum = 17'(sat_cnt_q);
    if (ld) begin
      for (int i = 0; i < N_CH; i++) sat_sum = sat_sum + 17'(lane_sat[i]);
    end
    sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    requant_lane #(
      .Z_WEIGHTS (Z_WEIGHTS),
      .Z_OUT     (Z_OUT),
      .OUT_SIGNED(OUT_SIGNED)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .ld_i   (ld),
      .acc_i  (acc[g*ACC_W +: ACC_W]),
      .ai_i   (ai),
      .bias_i (bias[g*ACC_W +: ACC_W]),
      .mul_i  (mul_q[g]),
      .shift_i(shift_q[g]),
      .q_o    (out_q[g*PRECISION +: PRECISION]),
      .sat_o  (lane_sat[g])
    );
  end

endmodule

// File: tb/tb_requant_pipeline.sv
// Directed + randomized bench for requant_pipeline against an arithmetic reference model.
module tb_requant_pipeline;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [127:0] acc, bias;
  logic [31:0]  ai;
  logic         out_valid, out_ready;
  logic [31:0]  out_q;
  logic         cfg_we, cfg_ready;
  logic [1:0]   cfg_ch;
  logic [31:0]  cfg_mul;
  logic [5:0]   cfg_shift;
  logic [15:0]  sat_cnt;

  always #5 clk = ~clk;

  requant_pipeline dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .acc(acc), .ai(ai), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mul(cfg_mul), .cfg_shift(cfg_shift), .sat_cnt(sat_cnt)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          m_sat = 0;
  longint      m_mul[4];
  int          m_shift[4];
  logic        last_ov, last_ir, last_cr;
  logic        stall_prev = 1'b0;
  logic [31:0] held_q;
  int          accepts = 0;
  int          outs = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // q = clamp(round_half_up((acc - 5*ai) * M / 2^S) + bias + Z_OUT), Z_OUT = 0
  function automatic logic [8:0] ref_lane(input logic signed [31:0] a, input logic signed [31:0] x,
                                          input logic signed [31:0] b, input longint m, input int s);
    logic signed [127:0] p, d, t, r, v;
    int lo;
    p = (128'(a) - 128'sd5 * 128'(x)) * 128'(m);
    if (s == 0) begin
      r = p;
    end else begin
      d = 128'sd1 <<< s;
      t = p + d / 2;
      r = t / d;
      if ((t % d) != 0 && t < 0) r = r - 1;
    end
    v = r + 128'(b);
`ifdef REQUANT_RELU_EN
    lo = 0;
`else
    lo = -128;
`endif
    if (v > 127) return {1'b1, 8'h7F};
    if (v < lo)  return {1'b1, 8'(lo)};
    return {1'b0, v[7:0]};
  endfunction

  task automatic push_expected();
    logic [31:0] q;
    logic [8:0]  r;
    for (int i = 0; i < 4; i++) begin
      r = ref_lane(acc[i*32 +: 32], ai, bias[i*32 +: 32], m_mul[i], m_shift[i]);
      q[i*8 +: 8] = r[7:0];
      m_sat += int'(r[8]);
    end
    exp_q.push_back(q);
  endtask

  // Called at a negedge with inputs already driven; samples, scores, advances to next negedge.
  task automatic tick();
    #1;
    last_ov = out_valid;
    last_ir = in_ready;
    last_cr = cfg_ready;
    if (stall_prev) check("stall_hold", {31'b0, out_valid, out_q}, {32'b1, held_q});
    if (out_valid && out_ready) begin
      outs++;
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("data", out_q, exp_q.pop_front());
    end
    stall_prev = out_valid && !out_ready;
    held_q     = out_q;
    if (in_valid && in_ready) begin
      accepts++;
      push_expected();
    end
    @(negedge clk);
  endtask

  task automatic drive_beat(input logic [127:0] a, input logic [31:0] x, input logic [127:0] b);
    int n = 0;
    in_valid = 1'b1; acc = a; ai = x; bias = b;
    tick();
    while (!last_ir && n < 50) begin tick(); n++; end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin tick(); lat++; end while (!last_ov && lat < 30);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [31:0] m, input logic [5:0] s,
                           output logic first_cr);
    int n = 0;
    cfg_we = 1'b1; cfg_ch = ch; cfg_mul = m; cfg_shift = s;
    tick();
    first_cr = last_cr;
    while (!last_cr && n < 50) begin tick(); n++; end
    check("cfg_accept", last_cr, 1);
    check("cfg_hold_in_ready", last_ir, 0);
    cfg_we = 1'b0;
    m_mul[ch] = {32'b0, m};
    m_shift[ch] = s;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1; in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [127:0] rand_small(input int span, input int off);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = 32'($urandom_range(0, span)) - 32'(off);
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int lat, base_acc, base_out, seen;
    logic fc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
    acc = '0; ai = '0; bias = '0; cfg_ch = '0; cfg_mul = '0; cfg_shift = '0;
    for (int i = 0; i < 4; i++) begin m_mul[i] = 1; m_shift[i] = 0; end
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_q", out_q, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: large multiplier, saturation of lane 0, latency
    cfg_write(2'd0, 32'h8000_0000, 6'd32, fc);
    drive_beat({32'd53, 32'd52, 32'd51, 32'd1000}, 32'd10, {96'd0, 32'd3});
    wait_out(lat);
    check("t1_latency", lat, 4);
    check("t1_lane0", out_q[7:0], 8'h7F);
    check("t1_sat_cnt", sat_cnt, 1);

    // Test 2: round half-up with SHIFT=1
    for (int i = 0; i < 4; i++) cfg_write(2'(i), 32'd1, 6'd1, fc);
    drive_beat({32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFF9, 32'd7}, 32'd0, 128'd0);
    wait_out(lat);
    check("t2_latency", lat, 4);
    check("t2_round", out_q, 32'hFE03_FD04);

    // Test 6: negative results, ReLU build or pass-through
    for (int i = 0; i < 4; i++) cfg_write(2'(i), 32'd1, 6'd0, fc);
    drive_beat({32'd0, 32'hFFFF_FFFF, 32'd20, 32'hFFFF_FF9C}, 32'd0, 128'd0);
    wait_out(lat);
`ifdef REQUANT_RELU_EN
    check("t6_relu", out_q, 32'h0000_1400);
`else
    check("t6_passthru", out_q, 32'h00FF_149C);
`endif
    check("t6_sat_cnt", sat_cnt, 16'(m_sat));

    // Test 3: random stream of 20 beats with out_ready pattern 1,0,0,1
    for (int i = 0; i < 4; i++)
      cfg_write(2'(i), 32'($urandom_range(1, 65535)), 6'($urandom_range(8, 20)), fc);
    base_acc = accepts; base_out = outs;
    for (int c = 0; c < 400 && (outs - base_out) < 20; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      if ((accepts - base_acc) >= 20) begin
        in_valid = 1'b0;
      end else if (!in_valid || last_ir) begin
        in_valid = ($urandom_range(0, 3) != 0);
        acc  = (c % 5 == 0) ? {$urandom, $urandom, $urandom, $urandom} : rand_small(8191, 4096);
        ai   = 32'($urandom_range(0, 200)) - 32'd100;
        bias = rand_small(127, 64);
      end
      tick();
    end
    check("t3_accepts", accepts - base_acc, 20);
    check("t3_outs", outs - base_out, 20);
    drain();
    check("t3_sat_cnt", sat_cnt, 16'(m_sat));

    // Test 4: config write while a beat is in flight
    drive_beat(rand_small(8191, 4096), 32'd7, rand_small(127, 64));
    base_out = outs;
    cfg_write(2'd2, 32'd3, 6'd2, fc);
    check("t4_busy", fc, 0);
    check("t4_old_beat_out", outs - base_out, 1);
    drive_beat(rand_small(8191, 4096), 32'd3, rand_small(127, 64));
    wait_out(lat);
    check("t4_latency", lat, 4);
    drain();

    // Test 5: asynchronous reset mid-stream
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; acc = rand_small(8191, 4096); ai = 32'd1; bias = rand_small(127, 64);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_out_q", out_q, 0);
    check("t5_sat_cnt", sat_cnt, 0);
    check("t5_cfg_ready", cfg_ready, 1);
    exp_q.delete(); stall_prev = 1'b0; m_sat = 0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin m_mul[i] = 1; m_shift[i] = 0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin tick(); seen += int'(last_ov); end
    check("t5_no_stale", seen, 0);
    drive_beat(rand_small(8191, 4096), 32'd2, rand_small(127, 64));
    wait_out(lat);
    check("t5_latency", lat, 4);
    drain();
    check("final_sat_cnt", sat_cnt, 16'(m_sat));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
